dtc_mon_scan: RTL and testbench
===============================

// Module: dtc_mon_scan
// PURPOSE
//  Sequencer for the 40:1 DTC monitor mux. Drives dtc_mon_sel across all unmasked DTC
//  links and waits out the mux pipeline. Samples each link's 16-bit deserialized word
//  NSAMP times and compares it with the expected idle pattern.
//  Keeps a sticky error flag and a saturating error count per link for the DCS; also
//  offers a manual-select mode when idle. Sits in the dcsclk domain between DCS regs and the mux.
// PARAMETERS
//  NCH     40  number of DTC links
//  SEL_W   6   width of dtc_mon_sel
//  DW      16  deserialized word width
//  SETTLE  2   cycles from sel update to first valid sample (mux adds 1 reg stage)
//  NSAMP   16  samples compared per link per pass
//  CNT_W   8   per-link error counter width (saturating)
// PORTS
//  dcsclk          in   1      DCS clock, sole clock
//  reset_n         in   1      reset, synchronous, active-low
//  scan_start      in   1      1-cycle pulse: begin one pass (ignored while busy)
//  scan_cont       in   1      1: restart a new pass automatically after each done
//  man_en          in   1      manual select enable (honoured only in IDLE)
//  man_sel         in   SEL_W  manual link index
//  exp_pattern     in   DW     expected idle word
//  dtc_mask        in   NCH    1 = link skipped by scan
//  dtc_deser_dout  in   DW     registered word from monitor mux
//  dtc_mon_sel     out  SEL_W  link select to monitor mux (registered)
//  scan_busy       out  1      pass in progress
//  scan_done       out  1      1-cycle pulse at end of pass
//  err_flags       out  NCH    sticky mismatch flag per link
//  rd_ch           in   SEL_W  readback link index
//  rd_cnt          out  CNT_W  error count of rd_ch, 1-cycle registered
//  err_clr         in   1      clear all err_flags and counters
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): FSM=IDLE, dtc_mon_sel=0, scan_busy=0, scan_done=0,
//   err_flags=0, all counters=0, rd_cnt=0. Reset mid-pass aborts immediately; no done pulse.
//  FSM: IDLE -> (scan_start | scan_cont) -> FIND.
//   FIND: search from current ch for next unmasked; none left -> DONE; else SEL.
//   SEL: register dtc_mon_sel=ch, load settle cnt=SETTLE-1 -> WAIT.
//   WAIT: count to 0 -> SAMP with sample cnt=0. SAMP: compare each cycle, NSAMP cycles.
//   NSAMP done -> ch+1; ch==NCH-1 -> DONE; else FIND.
//   DONE: scan_done=1 for 1 cycle, ch=0 -> IDLE; with scan_cont=1 -> FIND next cycle.
//  FIND costs 1 cycle per masked link skipped. Unmasked link occupies 1+SETTLE+NSAMP cycles.
//  All links masked: pass is FIND->DONE, scan_done still pulses, nothing compared.
//  Compare: dtc_deser_dout != exp_pattern in SAMP -> err_flags[ch]<=1,
//   cnt[ch]<=cnt+1 saturating at 2^CNT_W-1 (no wrap).
//  err_clr: same-cycle mismatch is dropped (clear wins); scan state is unaffected.
//  scan_busy=1 in every state except IDLE. scan_start while busy is ignored.
//  Manual: in IDLE with man_en=1, dtc_mon_sel<=man_sel (man_sel>=NCH -> 0); man_en ignored
//   while busy. In IDLE with man_en=0, dtc_mon_sel holds its last value.
//  rd_cnt<=cnt[rd_ch] each cycle; rd_ch>=NCH -> 0. exp_pattern/dtc_mask are sampled live;
//   DCS holds them stable while busy.
// STRUCTURE
//  Shared package: NCH/SEL_W/DW constants and the FSM state encoding
//   (IDLE,FIND,SEL,WAIT,SAMP,DONE).
//  One sub-module: dtc_err_bank (NCH saturating counters + sticky flags + readback mux,
//   inputs inc_en/inc_ch/clr/rd_ch). FSM and sel register stay in the top.
// TESTING
//  Bench drives dtc_deser_dout from a behavioural model of the monitor mux.
//  1 Reset, no mask, every word==exp_pattern=16'hA5A5, pulse start -> done after
//    40*(1+2+16)=760 busy cycles, err_flags=0.
//  2 Link 7 sends 16'h0000 for 3 samples -> err_flags=40'h80, rd_ch=7 gives rd_cnt=3
//    one cycle later.
//  3 dtc_mask=all ones except bits 0 and 39 -> only sel 0 and 39 driven; done after
//    2*19+38 skip cycles.
//  4 Link 2 mismatches continuously for 20 passes -> rd_cnt saturates at 255; err_clr
//    in a mismatch cycle -> cnt=0.
//  5 man_en=1, man_sel=45 in IDLE -> dtc_mon_sel=0. man_sel=12 -> 12. start with man_en=1
//    -> scan overrides.
//  6 reset_n=0 during WAIT of link 5 -> next cycle IDLE, busy=0, no done pulse, flags cleared.

Source files
------------

// File: rtl/dtc_mon_scan_pkg.sv
// Shared constants and scan FSM encoding for the DTC monitor-mux scan sequencer.
package dtc_mon_scan_pkg;

  localparam int unsigned NCH      = 40;
  localparam int unsigned SEL_W    = 6;
  localparam int unsigned DW       = 16;
  localparam int unsigned SETTLE   = 2;
  localparam int unsigned NSAMP    = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);
  localparam int unsigned SAMP_W   = $clog2(NSAMP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND,
    ST_SEL,
    ST_WAIT,
    ST_SAMP,
    ST_DONE
  } scan_state_e;

  // Out-of-range link indices fold to link 0
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    return (s < SEL_W'(NCH)) ? s : '0;
  endfunction

endpackage

// File: rtl/dtc_mon_scan_err.sv
// dtc_err_bank: per-link sticky mismatch flags, saturating error counters and readback mux.
module dtc_err_bank
  import dtc_mon_scan_pkg::*;
(
  input  logic             dcsclk,
  input  logic             reset_n,
  input  logic             inc_en,
  input  logic [SEL_W-1:0] inc_ch,
  input  logic             clr,
  input  logic [SEL_W-1:0] rd_ch,
  output logic [NCH-1:0]   err_flags,
  output logic [CNT_W-1:0] rd_cnt
);

  logic [CNT_W-1:0] cnt [NCH];

  // Clear takes priority over a same-cycle mismatch
  always_ff @(posedge dcsclk) begin
    if (!reset_n || clr) begin
      err_flags <= '0;
      for (int i = 0; i < int'(NCH); i++) cnt[i] <= '0;
    end else if (inc_en) begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (inc_ch == SEL_W'(i)) begin
          err_flags[i] <= 1'b1;
          if (cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Readback of a nonexistent link returns 0
  always_ff @(posedge dcsclk) begin
    if (!reset_n) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        if (rd_ch == SEL_W'(i)) rd_cnt <= cnt[i];
      end
    end
  end

endmodule

// File: rtl/dtc_mon_scan.sv
// dtc_mon_scan: steps dtc_mon_sel over unmasked DTC links and checks NSAMP words per link
// against the idle pattern; manual select is available while idle.
module dtc_mon_scan
  import dtc_mon_scan_pkg::*;
(
  input  logic             dcsclk,
  input  logic             reset_n,
  input  logic             scan_start,
  input  logic             scan_cont,
  input  logic             man_en,
  input  logic [SEL_W-1:0] man_sel,
  input  logic [DW-1:0]    exp_pattern,
  input  logic [NCH-1:0]   dtc_mask,
  input  logic [DW-1:0]    dtc_deser_dout,
  output logic [SEL_W-1:0] dtc_mon_sel,
  output logic             scan_busy,
  output logic             scan_done,
  output logic [NCH-1:0]   err_flags,
  input  logic [SEL_W-1:0] rd_ch,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             err_clr
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

  scan_state_e         state;
  logic [SEL_W-1:0]    ch;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [SAMP_W-1:0]   samp_cnt;
  logic                mis_c;

  assign mis_c = (state == ST_SAMP) && (dtc_deser_dout != exp_pattern);

  // Scan sequencer; the mux output register supplies the last settle cycle, so WAIT
  // exits when its countdown would reach zero.
  always_ff @(posedge dcsclk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ch          <= '0;
      settle_cnt  <= '0;
      samp_cnt    <= '0;
      dtc_mon_sel <= '0;
      scan_busy   <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scan_start || scan_cont) begin
            state     <= ST_FIND;
            ch        <= '0;
            scan_busy <= 1'b1;
          end else if (man_en) begin
            dtc_mon_sel <= clamp_sel(man_sel);
          end
        end
        ST_FIND: begin
          if (!dtc_mask[ch]) begin
            state <= ST_SEL;
          end else if (ch == LAST_CH) begin
            state     <= ST_DONE;
            scan_done <= 1'b1;
          end else begin
            ch <= ch + SEL_W'(1);
          end
        end
        ST_SEL: begin
          dtc_mon_sel <= ch;
          settle_cnt  <= SETTLE_W'(SETTLE - 1);
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (settle_cnt <= SETTLE_W'(1)) begin
            state    <= ST_SAMP;
            samp_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        ST_SAMP: begin
          if (samp_cnt == SAMP_W'(NSAMP - 1)) begin
            if (ch == LAST_CH) begin
              state     <= ST_DONE;
              scan_done <= 1'b1;
            end else begin
              ch    <= ch + SEL_W'(1);
              state <= ST_FIND;
            end
          end else begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
          end
        end
        ST_DONE: begin
          ch <= '0;
          if (scan_cont) begin
            state <= ST_FIND;
          end else begin
            state     <= ST_IDLE;
            scan_busy <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          scan_busy <= 1'b0;
        end
      endcase
    end
  end

  dtc_err_bank u_err_bank (
    .dcsclk    (dcsclk),
    .reset_n   (reset_n),
    .inc_en    (mis_c),
    .inc_ch    (ch),
    .clr       (err_clr),
    .rd_ch     (rd_ch),
    .err_flags (err_flags),
    .rd_cnt    (rd_cnt)
  );

endmodule

// File: tb/tb_dtc_mon_scan.sv
// Bench for dtc_mon_scan: behavioural monitor-mux model, per-pass reference model and
// a done-pulse scoreboard.
module tb_dtc_mon_scan;
  import dtc_mon_scan_pkg::*;

  logic             dcsclk = 1'b0;
  logic             reset_n, scan_start, scan_cont, man_en, err_clr;
  logic [SEL_W-1:0] man_sel, rd_ch, dtc_mon_sel;
  logic [DW-1:0]    exp_pattern;
  logic [DW-1:0]    dtc_deser_dout = '0;
  logic [NCH-1:0]   dtc_mask, err_flags;
  logic             scan_busy, scan_done;
  logic [CNT_W-1:0] rd_cnt;

  dtc_mon_scan dut (
    .dcsclk         (dcsclk),
    .reset_n        (reset_n),
    .scan_start     (scan_start),
    .scan_cont      (scan_cont),
    .man_en         (man_en),
    .man_sel        (man_sel),
    .exp_pattern    (exp_pattern),
    .dtc_mask       (dtc_mask),
    .dtc_deser_dout (dtc_deser_dout),
    .dtc_mon_sel    (dtc_mon_sel),
    .scan_busy      (scan_busy),
    .scan_done      (scan_done),
    .err_flags      (err_flags),
    .rd_ch          (rd_ch),
    .rd_cnt         (rd_cnt),
    .err_clr        (err_clr)
  );

  always #5 dcsclk = ~dcsclk;

  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int ALWAYS  = 1000000;
  localparam int UNIT    = 1 + int'(SETTLE) + int'(NSAMP);

  typedef struct {
    int             cycles;
    logic [NCH-1:0] flags;
  } exp_t;

  exp_t           sb_q[$];
  int             checks = 0, errors = 0, done_seen = 0, n_done_exp = 0;
  int             bad_n    [NCH];
  logic [DW-1:0]  bad_word [NCH];
  int             m_cnt    [NCH];
  logic [NCH-1:0] m_flags;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor mux: link k emits bad_word[k] for its first bad_n[k] words after being selected
  logic [SEL_W-1:0] last_sel = '0;
  int widx = 0;
  int cur_link = -1, cur_idx = 0;
  always @(posedge dcsclk) begin
    if (dtc_mon_sel != last_sel) widx = 0;
    else widx++;
    last_sel = dtc_mon_sel;
    cur_link <= int'(dtc_mon_sel);
    cur_idx  <= widx;
    if (int'(dtc_mon_sel) < int'(NCH) && widx < bad_n[dtc_mon_sel])
      dtc_deser_dout <= bad_word[dtc_mon_sel];
    else
      dtc_deser_dout <= exp_pattern;
  end

  // Scoreboard monitor: each done pulse pops one expected pass result
  int   busy_cyc  = 0;
  logic prev_done = 1'b0;
  always @(negedge dcsclk) begin
    exp_t e;
    if (!reset_n) begin
      busy_cyc  = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_width", longint'(scan_done), 0);
      if (scan_done) begin
        done_seen++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("pass_cycles", busy_cyc, e.cycles);
          chk("pass_flags", longint'(err_flags), longint'(e.flags));
          chk("busy_at_done", longint'(scan_busy), 1);
        end
        busy_cyc = 0;
      end else if (scan_busy) begin
        busy_cyc++;
      end
      prev_done = scan_done;
    end
  end

  task automatic tick();
    @(negedge dcsclk);
  endtask

  function automatic int pass_cycles(input logic [NCH-1:0] m);
    int c = 0;
    for (int k = 0; k < int'(NCH); k++) c += m[k] ? 1 : UNIT;
    return c;
  endfunction

  task automatic model_pass(input logic [NCH-1:0] m);
    exp_t e;
    int   n;
    for (int k = 0; k < int'(NCH); k++) begin
      if (!m[k]) begin
        n = (bad_n[k] > int'(NSAMP)) ? int'(NSAMP) : bad_n[k];
        if (n > 0) begin
          m_flags[k] = 1'b1;
          m_cnt[k]   = (m_cnt[k] + n > CMAX) ? CMAX : m_cnt[k] + n;
        end
      end
    end
    e.cycles = pass_cycles(m);
    e.flags  = m_flags;
    sb_q.push_back(e);
    n_done_exp++;
  endtask

  task automatic model_clear();
    m_flags = '0;
    for (int k = 0; k < int'(NCH); k++) m_cnt[k] = 0;
  endtask

  function automatic int first_unmasked(input logic [NCH-1:0] m);
    for (int k = 0; k < int'(NCH); k++) if (!m[k]) return k;
    return int'(NCH);
  endfunction

  // Move the select away from the first link so the mux sees a fresh selection
  task automatic park(input logic [NCH-1:0] m);
    man_en  = 1'b1;
    man_sel = (first_unmasked(m) == 0) ? SEL_W'(1) : SEL_W'(0);
    tick();
    man_en  = 1'b0;
  endtask

  task automatic wait_idle(input int target, input int limit);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((scan_busy || done_seen < target) && n < limit);
    chk("idle_timeout", longint'(n < limit), 1);
  endtask

  task automatic run_pass(input logic [NCH-1:0] m);
    dtc_mask = m;
    park(m);
    model_pass(m);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_idle(n_done_exp, 3000);
  endtask

  task automatic rd_check(input int k);
    rd_ch = SEL_W'(k);
    tick();
    chk($sformatf("rd_cnt[%0d]", k), longint'(rd_cnt), (k < int'(NCH)) ? m_cnt[k] : 0);
  endtask

  initial begin
    logic [NCH-1:0] m;
    int n;
    reset_n = 1'b0; scan_start = 1'b0; scan_cont = 1'b0; man_en = 1'b0; err_clr = 1'b0;
    man_sel = '0; rd_ch = '0; exp_pattern = 16'hA5A5; dtc_mask = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      bad_n[k] = 0;
      bad_word[k] = 16'h0000;
    end
    model_clear();
    repeat (3) tick();
    chk("rst_sel", longint'(dtc_mon_sel), 0);
    chk("rst_busy", longint'(scan_busy), 0);
    chk("rst_done", longint'(scan_done), 0);
    chk("rst_flags", longint'(err_flags), 0);
    chk("rst_rd_cnt", longint'(rd_cnt), 0);
    reset_n = 1'b1;
    tick();

    // All links clean
    run_pass('0);
    chk("clean_flags", longint'(err_flags), 0);

    // Link 7 bad for 3 samples
    bad_n[7] = 3;
    run_pass('0);
    bad_n[7] = 0;
    chk("link7_flags", longint'(err_flags), 40'h80);
    rd_check(7);

    // Only links 0 and 39 scanned; all others would mismatch if visited
    for (int k = 1; k < int'(NCH) - 1; k++) bad_n[k] = ALWAYS;
    m = '1; m[0] = 1'b0; m[NCH-1] = 1'b0;
    run_pass(m);
    for (int k = 0; k < int'(NCH); k++) bad_n[k] = 0;
    chk("edge_links_sel", longint'(dtc_mon_sel), NCH - 1);

    // Manual select
    man_en = 1'b1; man_sel = 6'd12; tick();
    chk("man_sel_12", longint'(dtc_mon_sel), 12);
    man_sel = 6'd45; tick();
    chk("man_sel_45", longint'(dtc_mon_sel), 0);
    man_en = 1'b0; man_sel = 6'd20; tick();
    chk("man_hold", longint'(dtc_mon_sel), 0);
    man_en = 1'b1; man_sel = 6'd12; tick();
    m = '1; m[30] = 1'b0; dtc_mask = m;
    model_pass(m);
    man_sel = 6'd7; scan_start = 1'b1; tick(); scan_start = 1'b0;
    chk("start_overrides_man", longint'(dtc_mon_sel), 12);
    wait_idle(n_done_exp, 3000);
    chk("man_ignored_busy", longint'(dtc_mon_sel), 30);
    tick();
    chk("man_after_idle", longint'(dtc_mon_sel), 7);
    man_en = 1'b0;

    // Continuous scan of link 2 until its counter saturates
    model_clear();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    m = '1; m[2] = 1'b0; dtc_mask = m;
    bad_n[2] = ALWAYS; bad_word[2] = ~exp_pattern;
    park(m);
    for (int p = 0; p < 20; p++) model_pass(m);
    scan_cont = 1'b1;
    n = 0;
    while (done_seen < n_done_exp - 1 && n < 5000) begin
      tick();
      n++;
    end
    scan_cont = 1'b0;
    wait_idle(n_done_exp, 3000);
    rd_check(2);
    chk("sat_value", longint'(rd_cnt), CMAX);

    // Clear during the final mismatching sample of link 2
    park(m);
    begin
      exp_t e;
      e.cycles = pass_cycles(m);
      e.flags  = '0;
      sb_q.push_back(e);
      n_done_exp++;
    end
    model_clear();
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    n = 0;
    while (!(cur_link == 2 && cur_idx == int'(NSAMP) - 1) && n < 500) begin
      tick();
      n++;
    end
    chk("clr_window_timeout", longint'(n < 500), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    wait_idle(n_done_exp, 3000);
    rd_check(2);
    bad_n[2] = 0;

    // Randomized passes
    for (int p = 0; p < 6; p++) begin
      exp_pattern = DW'($urandom);
      for (int k = 0; k < int'(NCH); k++) begin
        case ($urandom_range(0, 3))
          1: bad_n[k] = int'($urandom_range(1, NSAMP));
          2: bad_n[k] = ALWAYS;
          default: bad_n[k] = 0;
        endcase
        bad_word[k] = exp_pattern ^ DW'($urandom_range(1, 65535));
      end
      m = NCH'({$urandom, $urandom}) & NCH'({$urandom, $urandom});
      if (p == 2) m = '1;
      if ($urandom_range(0, 2) == 0) begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        model_clear();
      end
      run_pass(m);
      rd_check(int'($urandom_range(0, NCH - 1)));
      rd_check(int'($urandom_range(0, 63)));
    end

    // Reset while link 5 is settling
    exp_pattern = 16'hA5A5;
    for (int k = 0; k < int'(NCH); k++) begin
      bad_n[k] = 0;
      bad_word[k] = 16'h0000;
    end
    bad_n[3] = ALWAYS;
    m = '1; m[3] = 1'b0; m[5] = 1'b0; dtc_mask = m;
    park(m);
    scan_start = 1'b1; tick(); scan_start = 1'b0;
    n = 0;
    while (dtc_mon_sel != SEL_W'(5) && n < 500) begin
      tick();
      n++;
    end
    chk("wait5_timeout", longint'(n < 500), 1);
    chk("pre_reset_flag3", longint'(err_flags[3]), 1);
    reset_n = 1'b0;
    tick();
    sb_q.delete();
    n_done_exp = done_seen;
    model_clear();
    chk("abort_busy", longint'(scan_busy), 0);
    chk("abort_done", longint'(scan_done), 0);
    chk("abort_flags", longint'(err_flags), 0);
    chk("abort_sel", longint'(dtc_mon_sel), 0);
    tick();
    reset_n = 1'b1;
    repeat (40) tick();
    chk("abort_no_done", done_seen, n_done_exp);
    rd_check(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
